rep_window_checker: RTL and testbench

//  Synthesizable downstream consumer of the a/b monitor stimulus.

---
 rtl/rep_window_checker_pkg.sv | 23 ++
 rtl/rep_window_checker_sat.sv | 27 ++
 rtl/rep_window_checker.sv | 114 +++++++++++
 tb/tb_rep_window_checker.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rep_window_checker_pkg.sv
// Shared types and default sizing for the a/b repetition window checker.
// The top module derives its own window-counter width from MAX_WINDOW.

package rep_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int REP_COUNT_DEF  = 3;
    localparam int CNT_W_DEF      = 4;
    localparam int MAX_WINDOW_DEF = 64;

    // The window counter must hold values up to MAX_WINDOW itself.
    function automatic int win_width(input int max_window);
        return $clog2(max_window + 1);
    endfunction

    localparam int WIN_W = win_width(MAX_WINDOW_DEF);

endpackage

// File: rtl/rep_window_checker_sat.sv
// Saturating up-counter used for the per-window hit count.
// clr reloads the counter with the current inc value so the opening cycle's hit is kept.

module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         sat
);

    assign sat = &q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= W'(inc);
        end else if (inc && !sat) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/rep_window_checker.sv
// Counts a&&b hits inside a start/stop window and reports pass when the
// window saw exactly REP_COUNT hits (on-chip form of the [=N] repetition check).

module rep_window_checker
    import rep_chk_pkg::*;
#(
    parameter int REP_COUNT  = REP_COUNT_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int MAX_WINDOW = MAX_WINDOW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic [CNT_W-1:0] hit_count,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic             overflow
);

    localparam int LW = win_width(MAX_WINDOW);

    state_t          state;
    state_t          state_next;
    logic [LW-1:0]   win_cnt;
    logic            overflow_q;
    logic            timeout_q;
    logic            timeout_next;
    logic            accept;
    logic            hit;
    logic            cnt_inc;
    logic            cnt_sat;
    logic            report_ok;

    assign hit     = a && b;
    assign cnt_inc = hit && (accept || (state == COUNT));

    sat_counter #(
        .W(CNT_W)
    ) u_hit_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .inc   (cnt_inc),
        .q     (hit_count),
        .sat   (cnt_sat)
    );

    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        timeout_next = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (stop) begin
                        state_next = REPORT;
                    end else if (MAX_WINDOW <= 1) begin
                        state_next   = REPORT;
                        timeout_next = 1'b1;
                    end else begin
                        state_next = COUNT;
                    end
                end
            end
            COUNT: begin
                // win_cnt lags the window cycle index by one, so MAX_WINDOW-1 marks the last cycle
                if (stop) begin
                    state_next = REPORT;
                end else if (win_cnt >= LW'(MAX_WINDOW - 1)) begin
                    state_next   = REPORT;
                    timeout_next = 1'b1;
                end
            end
            REPORT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            win_cnt    <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state     <= state_next;
            timeout_q <= timeout_next;
            if (accept) begin
                win_cnt    <= LW'(1);
                overflow_q <= 1'b0;
            end else if (state == COUNT) begin
                win_cnt <= win_cnt + LW'(1);
                if (hit && cnt_sat) begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    assign report_ok = (hit_count == CNT_W'(REP_COUNT)) && !overflow_q && !timeout_q;

    assign busy     = (state != IDLE);
    assign pass     = (state == REPORT) && report_ok;
    assign fail     = (state == REPORT) && !report_ok;
    assign timeout  = (state == REPORT) && timeout_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_rep_window_checker.sv
// Self-checking bench: three checker instances (default, short window, narrow counter)
// share one stimulus stream and are compared against a window-level reference model.

module tb_rep_window_checker;

    logic clk;
    logic reset;
    logic start;
    logic stop;
    logic a;
    logic b;

    logic       busy0, pass0, fail0, to0, ovf0;
    logic [3:0] hc0;
    logic       busy1, pass1, fail1, to1, ovf1;
    logic [3:0] hc1;
    logic       busy2, pass2, fail2, to2, ovf2;
    logic [1:0] hc2;

    logic [8:0] obs [3];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit open;
        bit report;
        int len;
        int hits;
        bit pass;
        bit fail;
        bit to;
    } mdl_t;

    mdl_t mdl [3];
    int   rep_p [3] = '{3, 3, 3};
    int   cw_p  [3] = '{4, 4, 2};
    int   mw_p  [3] = '{64, 8, 64};

    rep_window_checker dut0 (
        .clk(clk), .reset(reset), .a(a), .b(b), .start(start), .stop(stop),
        .busy(busy0), .hit_count(hc0), .pass(pass0), .fail(fail0),
        .timeout(to0), .overflow(ovf0)
    );

    rep_window_checker #(.REP_COUNT(3), .CNT_W(4), .MAX_WINDOW(8)) dut1 (
        .clk(clk), .reset(reset), .a(a), .b(b), .start(start), .stop(stop),
        .busy(busy1), .hit_count(hc1), .pass(pass1), .fail(fail1),
        .timeout(to1), .overflow(ovf1)
    );

    rep_window_checker #(.REP_COUNT(3), .CNT_W(2), .MAX_WINDOW(64)) dut2 (
        .clk(clk), .reset(reset), .a(a), .b(b), .start(start), .stop(stop),
        .busy(busy2), .hit_count(hc2), .pass(pass2), .fail(fail2),
        .timeout(to2), .overflow(ovf2)
    );

    assign obs[0] = {busy0, hc0, pass0, fail0, to0, ovf0};
    assign obs[1] = {busy1, hc1, pass1, fail1, to1, ovf1};
    assign obs[2] = {busy2, 2'b00, hc2, pass2, fail2, to2, ovf2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Window-level reference: raw hit total and window length, outputs derived at the end.
    function automatic mdl_t model_step(input mdl_t m, input bit rst, input bit st,
                                        input bit sp, input bit hit, input int rep,
                                        input int maxw);
        mdl_t n;
        bit   closing;
        bit   timed;
        n       = m;
        closing = 1'b0;
        timed   = 1'b0;
        n.pass  = 1'b0;
        n.fail  = 1'b0;
        n.to    = 1'b0;
        n.report = 1'b0;
        if (rst) begin
            n = '{default: 0};
            return n;
        end
        if (m.open) begin
            n.len  = m.len + 1;
            n.hits = m.hits + int'(hit);
            timed   = !sp && (n.len == maxw);
            closing = sp || timed;
        end else if (!m.report && st) begin
            n.open = 1'b1;
            n.len  = 1;
            n.hits = int'(hit);
            timed   = !sp && (maxw == 1);
            closing = sp || timed;
        end
        if (closing) begin
            n.open   = 1'b0;
            n.report = 1'b1;
            n.pass   = (n.hits == rep) && !timed;
            n.fail   = !n.pass;
            n.to     = timed;
        end
        return n;
    endfunction

    function automatic logic [8:0] exp_vec(input mdl_t m, input int cw);
        int cap;
        int hc;
        cap = (1 << cw) - 1;
        hc  = (m.hits > cap) ? cap : m.hits;
        return {m.open || m.report, 4'(hc), m.pass, m.fail, m.to, m.hits > cap};
    endfunction

    task automatic drive(input bit r, input bit s, input bit p, input bit aa, input bit bb);
        reset = r;
        start = s;
        stop  = p;
        a     = aa;
        b     = bb;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            mdl[i] = model_step(mdl[i], r, s, p, aa && bb, rep_p[i], mw_p[i]);
        end
        @(negedge clk);
    endtask

    // Drives window cycles 1..len; hit in cycle c when mask[c] is set.
    task automatic run_window(input logic [15:0] mask, input int len, input bit do_stop);
        for (int c = 1; c <= len; c++) begin
            drive(1'b0, c == 1, do_stop && (c == len), mask[c], mask[c]);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs[i] !== 9'd0) begin
                n_fail++;
                $display("[TB] FAIL test_reset dut%0d: got %b, expected %b", i, obs[i], 9'd0);
            end
        end
    endtask

    task automatic test_exact_hits;
        logic [15:0] masks [3];
        logic [3:0]  want  [3];
        masks[0] = 16'b0000_0000_0010_1010;
        masks[1] = 16'b0000_0000_0000_1010;
        masks[2] = 16'b0000_0000_0110_1010;
        want[0] = 4'd3;
        want[1] = 4'd2;
        want[2] = 4'd4;
        for (int k = 0; k < 3; k++) begin
            run_window(masks[k], 7, 1'b1);
            n_checks++;
            if (pass0 !== (k == 0) || fail0 !== (k != 0) || hc0 !== want[k] || to0 !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL exact_hits case %0d: pass=%b fail=%b hc=%0d, expected pass=%b fail=%b hc=%0d",
                         k, pass0, fail0, hc0, k == 0, k != 0, want[k]);
            end
            idle_cycles(2);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs[i] !== exp_vec(mdl[i], cw_p[i])) begin
                    n_fail++;
                    $display("[TB] FAIL exact_hits_hold case %0d dut%0d: got %b, expected %b",
                             k, i, obs[i], exp_vec(mdl[i], cw_p[i]));
                end
            end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_timeout;
        run_window(16'b0000_0000_0010_1010, 8, 1'b0);
        n_checks++;
        if (fail1 !== 1'b1 || to1 !== 1'b1 || pass1 !== 1'b0 || hc1 !== 4'd3) begin
            n_fail++;
            $display("[TB] FAIL timeout_no_stop: fail=%b timeout=%b pass=%b hc=%0d, expected 1 1 0 3",
                     fail1, to1, pass1, hc1);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_window(16'b0000_0000_0010_1010, 8, 1'b1);
        n_checks++;
        if (pass1 !== 1'b1 || to1 !== 1'b0 || fail1 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL timeout_stop_wins: pass=%b timeout=%b fail=%b, expected 1 0 0",
                     pass1, to1, fail1);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs[i] !== exp_vec(mdl[i], cw_p[i])) begin
                n_fail++;
                $display("[TB] FAIL timeout_model dut%0d: got %b, expected %b",
                         i, obs[i], exp_vec(mdl[i], cw_p[i]));
            end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_overflow;
        run_window(16'b0000_0000_0011_1110, 6, 1'b1);
        n_checks++;
        if (hc2 !== 2'd3 || ovf2 !== 1'b1 || fail2 !== 1'b1 || pass2 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL overflow: hc=%0d ovf=%b fail=%b pass=%b, expected 3 1 1 0",
                     hc2, ovf2, fail2, pass2);
        end
        idle_cycles(1);
        n_checks++;
        if (ovf2 !== 1'b1 || hc2 !== 2'd3 || busy2 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL overflow_hold: ovf=%b hc=%0d busy=%b, expected 1 3 0", ovf2, hc2, busy2);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_window;
        run_window(16'b0000_0000_0000_1010, 3, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs[i] !== 9'd0) begin
                n_fail++;
                $display("[TB] FAIL reset_mid dut%0d: got %b, expected %b", i, obs[i], 9'd0);
            end
        end
        run_window(16'b0000_0000_0010_1010, 7, 1'b1);
        n_checks++;
        if (pass0 !== 1'b1 || hc0 !== 4'd3 || fail0 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_restart: pass=%b hc=%0d fail=%b, expected 1 3 0",
                     pass0, hc0, fail0);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (fail0 !== 1'b1 || pass0 !== 1'b0 || hc0 !== 4'd0 || busy0 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL one_cycle_window: fail=%b pass=%b hc=%0d busy=%b, expected 1 0 0 1",
                     fail0, pass0, hc0, busy0);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            drive(1'b0, (c == 1) || (c == 4), c == 7, c[0], c[0]);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (busy0 !== 1'b0 || hc0 !== 4'd4 || fail0 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL ignored_start: busy=%b hc=%0d fail=%b, expected 0 4 0", busy0, hc0, fail0);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs[i] !== exp_vec(mdl[i], cw_p[i])) begin
                n_fail++;
                $display("[TB] FAIL ignored_start_model dut%0d: got %b, expected %b",
                         i, obs[i], exp_vec(mdl[i], cw_p[i]));
            end
        end
    endtask

    task automatic test_random;
        bit r, s, p, aa, bb;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r  = ($urandom_range(0, 299) == 0);
            s  = ($urandom_range(0, 4) == 0);
            p  = ($urandom_range(0, 9) == 0);
            aa = ($urandom_range(0, 2) != 0);
            bb = ($urandom_range(0, 2) != 0);
            drive(r, s, p, aa, bb);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs[i] !== exp_vec(mdl[i], cw_p[i])) begin
                    n_fail++;
                    $display("[TB] FAIL random cycle %0d dut%0d: got %b, expected %b",
                             cyc, i, obs[i], exp_vec(mdl[i], cw_p[i]));
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        a     = 1'b0;
        b     = 1'b0;
        for (int i = 0; i < 3; i++) mdl[i] = '{default: 0};
        test_reset();
        test_exact_hits();
        test_timeout();
        test_overflow();
        test_reset_mid_window();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
